// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the PRNG health monitor: the monitor state encoding
// and the default widths/cutoffs used as parameter defaults.
// -----------------------------------------------------------------------------
package prng_pkg;

    // Encoding is visible on the monitor's state output: 0=STARTUP, 1=RUN, 2=ALARM.
    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    localparam int DEF_N             = 32;
    localparam int DEF_RCT_CUTOFF    = 4;
    localparam int DEF_APT_WINDOW    = 64;
    localparam int DEF_APT_CUTOFF    = 8;
    localparam int DEF_STARTUP_WORDS = 64;

endpackage

// File: rtl/prng_health_tests.sv
// -----------------------------------------------------------------------------
// prng_health_tests
// Repetition-count test (RCT) and adaptive-proportion test (APT) over the
// accepted word stream. The fail outputs flag the word presented this cycle;
// they are only meaningful while accept is high.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   accept     : word is consumed and tested this cycle
//   word       : N-bit word under test
//   clear      : synchronous clear of all test history
//   rct_fail   : this word completes a run of RCT_CUTOFF identical words
//   apt_fail   : this word brings the window's reference-byte count to APT_CUTOFF
// -----------------------------------------------------------------------------
module prng_health_tests
    import prng_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW = DEF_APT_WINDOW,
    parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic [N-1:0] word,
    input  logic         clear,
    output logic         rct_fail,
    output logic         apt_fail
);

    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
    localparam int APT_W = $clog2(APT_CUTOFF + 1);
    localparam int WIN_W = $clog2(APT_WINDOW);

    localparam logic [RCT_W-1:0] RCT_LIMIT = RCT_W'(RCT_CUTOFF);
    localparam logic [APT_W-1:0] APT_LIMIT = APT_W'(APT_CUTOFF);

    logic [N-1:0]     r_prev_word;
    logic             r_prev_valid;
    logic [RCT_W-1:0] r_rct_cnt;
    logic [APT_W-1:0] r_apt_cnt;
    logic [WIN_W-1:0] r_win_idx;
    logic [7:0]       r_ref_byte;

    logic [RCT_W-1:0] w_rct_next;
    logic [APT_W-1:0] w_apt_next;

    // Counter values this word would produce; the fail checks compare against
    // the updated count, so the word that reaches the cutoff is the failing one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        w_rct_next = RCT_W'(1);
        w_apt_next = r_apt_cnt;

        if (r_prev_valid && (word == r_prev_word)) begin
            w_rct_next = (r_rct_cnt == '1) ? r_rct_cnt : r_rct_cnt + 1'b1;
        end

        // Window start: this word's low byte becomes the new reference.
        if (r_win_idx == '0) begin
            w_apt_next = APT_W'(1);
        end else if ((word[7:0] == r_ref_byte) && (r_apt_cnt != '1)) begin
            w_apt_next = r_apt_cnt + 1'b1;
        end
    end

    assign rct_fail = accept && (w_rct_next == RCT_LIMIT);
    assign apt_fail = accept && (w_apt_next == APT_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_word  <= '0;
            r_prev_valid <= 1'b0;
            r_rct_cnt    <= '0;
            r_apt_cnt    <= '0;
            r_win_idx    <= '0;
            r_ref_byte   <= '0;
        end else if (clear) begin
            r_prev_word  <= '0;
            r_prev_valid <= 1'b0;
            r_rct_cnt    <= '0;
            r_apt_cnt    <= '0;
            r_win_idx    <= '0;
            r_ref_byte   <= '0;
        end else if (accept) begin
            r_prev_word  <= word;
            r_prev_valid <= 1'b1;
            r_rct_cnt    <= w_rct_next;
            r_apt_cnt    <= w_apt_next;
            r_win_idx    <= r_win_idx + 1'b1;  // wraps at APT_WINDOW (power of 2)
            if (r_win_idx == '0) begin
                r_ref_byte <= word[7:0];
            end
        end
    end

endmodule

// File: rtl/prng_health_monitor.sv
// -----------------------------------------------------------------------------
// prng_health_monitor
// Health-tests a PRNG word stream, drops a start-up block, forwards healthy
// words through one output register, and latches a sticky alarm (blocking
// output) on any test failure.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_data/in_valid     : word stream from the generator
//   in_ready             : monitor takes in_data this cycle
//   out_data/out_valid   : registered healthy word to the consumer
//   out_ready            : consumer takes out_data
//   clear_alarm          : one-cycle pulse, leaves ALARM for STARTUP
//   alarm_rct, alarm_apt : sticky failure flags
//   state                : 0=STARTUP, 1=RUN, 2=ALARM
//   fail_count           : saturating count of ALARM entries since reset
// -----------------------------------------------------------------------------
module prng_health_monitor
    import prng_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF,
    parameter int APT_WINDOW    = DEF_APT_WINDOW,
    parameter int APT_CUTOFF    = DEF_APT_CUTOFF,
    parameter int STARTUP_WORDS = DEF_STARTUP_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         clear_alarm,
    output logic         alarm_rct,
    output logic         alarm_apt,
    output logic [1:0]   state,
    output logic [7:0]   fail_count
);

    localparam int SU_W = $clog2(STARTUP_WORDS + 1);
    localparam logic [SU_W-1:0] SU_LIMIT = SU_W'(STARTUP_WORDS);

    state_t          r_state;
    state_t          w_next_state;
    logic [SU_W-1:0] r_startup_cnt;
    logic [N-1:0]    r_out_data;
    logic            r_out_valid;
    logic            r_alarm_rct;
    logic            r_alarm_apt;
    logic [7:0]      r_fail_count;

    logic            w_accept;
    logic            w_test_accept;
    logic            w_clear;
    logic            w_rct_fail;
    logic            w_apt_fail;
    logic            w_fail;
    logic [SU_W-1:0] w_startup_next;

    // Only RUN applies backpressure; STARTUP and ALARM always consume.
    assign in_ready      = (r_state == ST_RUN) ? (!r_out_valid || out_ready) : 1'b1;
    assign w_accept      = in_valid && in_ready;
    assign w_test_accept = w_accept && (r_state != ST_ALARM);
    assign w_clear       = (r_state == ST_ALARM) && clear_alarm;
    assign w_fail        = w_rct_fail || w_apt_fail;
    assign w_startup_next = (r_startup_cnt == '1) ? r_startup_cnt : r_startup_cnt + 1'b1;

    prng_health_tests #(
        .N          (N),
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_tests (
        .clk      (clk),
        .reset    (reset),
        .accept   (w_test_accept),
        .word     (in_data),
        .clear    (w_clear),
        .rct_fail (w_rct_fail),
        .apt_fail (w_apt_fail)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Failure outranks the STARTUP->RUN step.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_STARTUP: begin
                if (w_fail) begin
                    w_next_state = ST_ALARM;
                end else if (w_test_accept && (w_startup_next == SU_LIMIT)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fail) begin
                    w_next_state = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (clear_alarm) begin
                    w_next_state = ST_STARTUP;
                end
            end
            default: w_next_state = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_startup_cnt <= '0;
        end else if (w_clear) begin
            r_startup_cnt <= '0;
        end else if (w_test_accept && (r_state == ST_STARTUP)) begin
            r_startup_cnt <= w_startup_next;
        end
    end

    // Output register: a failing word is never loaded, and a failure also
    // discards whatever word is still waiting for the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_fail || (r_state != ST_RUN)) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alarm_rct  <= 1'b0;
            r_alarm_apt  <= 1'b0;
            r_fail_count <= '0;
        end else if (w_clear) begin
            r_alarm_rct <= 1'b0;
            r_alarm_apt <= 1'b0;
        end else if (w_fail) begin
            r_alarm_rct <= r_alarm_rct || w_rct_fail;
            r_alarm_apt <= r_alarm_apt || w_apt_fail;
            if (r_fail_count != 8'hFF) begin
                r_fail_count <= r_fail_count + 8'd1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign alarm_rct  = r_alarm_rct;
    assign alarm_apt  = r_alarm_apt;
    assign state      = r_state;
    assign fail_count = r_fail_count;

endmodule
